// File: rtl/h2f_mailbox_slave.sv
// h2f_mailbox_slave: Avalon-MM register window with a TX and an RX 32-bit mailbox FIFO
module h2f_mailbox_slave #(
  parameter int DEPTH = 16,
  parameter logic [31:0] ID_VALUE = 32'hC5B0_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LW-1:0] tx_level, rx_level, tx_level_nx, rx_level_nx;
  logic [31:0] scratch, rd_mux, be_mask, status;
  logic tx_ovf, rx_unf, rd, tx_full, tx_empty, rx_full, rx_empty;
  logic tx_flush, rx_flush, clr, tx_wr, tx_push, tx_pop, rx_push, rx_pop, rx_pop_req;
  always_comb begin
    rd = avs_read && !avs_write;
    tx_full = tx_level == LW'(DEPTH);
    tx_empty = tx_level == '0;
    rx_full = rx_level == LW'(DEPTH);
    rx_empty = rx_level == '0;
    tx_flush = avs_write && avs_address == 3'd5 && avs_writedata[0];
    rx_flush = avs_write && avs_address == 3'd5 && avs_writedata[1];
    clr = avs_write && avs_address == 3'd5 && avs_writedata[2];
    tx_wr = avs_write && avs_address == 3'd2;
    tx_push = tx_wr && !tx_full;
    tx_pop = !tx_empty && tx_ready;
    rx_push = rx_valid && rx_ready;
    rx_pop_req = rd && avs_address == 3'd3;
    rx_pop = rx_pop_req && !rx_empty;
    tx_level_nx = tx_flush ? '0 : tx_level + LW'(tx_push) - LW'(tx_pop);
    rx_level_nx = rx_flush ? '0 : rx_level + LW'(rx_push) - LW'(rx_pop);
    tx_valid = !tx_empty;
    tx_data = tx_valid ? tx_mem[tx_rp] : '0;
    be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}}, {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    status = {10'd0, rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full, 8'(rx_level), 8'(tx_level)};
    rd_mux = avs_address == 3'd0 ? ID_VALUE :
             avs_address == 3'd1 ? scratch :
             avs_address == 3'd3 ? (rx_empty ? '0 : rx_mem[rx_rp]) :
             avs_address == 3'd4 ? status : '0;
  end
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= avs_writedata;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      tx_level <= '0;
      rx_level <= '0;
      rx_ready <= 1'b0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      scratch <= '0;
      avs_readdata <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      tx_level <= tx_level_nx;
      rx_level <= rx_level_nx;
      tx_wp <= tx_flush ? '0 : tx_wp + AW'(tx_push);
      tx_rp <= tx_flush ? '0 : tx_rp + AW'(tx_pop);
      rx_wp <= rx_flush ? '0 : rx_wp + AW'(rx_push);
      rx_rp <= rx_flush ? '0 : rx_rp + AW'(rx_pop);
      rx_ready <= rx_level_nx < LW'(DEPTH);
      tx_ovf <= (tx_ovf && !clr) || (tx_wr && tx_full);
      rx_unf <= (rx_unf && !clr) || (rx_pop_req && rx_empty);
      if (avs_write && avs_address == 3'd1) scratch <= (scratch & ~be_mask) | (avs_writedata & be_mask);
      avs_readdatavalid <= rd;
      if (rd) avs_readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_h2f_mailbox_slave.sv
// tb_h2f_mailbox_slave: directed register-table and corner-case sequences for the mailbox slave
module tb_h2f_mailbox_slave;
  logic clk = 0, reset = 1;
  logic [2:0] avs_address = '0;
  logic avs_read = 0, avs_write = 0;
  logic [31:0] avs_writedata = '0;
  logic [3:0] avs_byteenable = '0;
  logic [31:0] avs_readdata, tx_data, rx_data = '0;
  logic avs_readdatavalid, tx_valid, tx_ready = 0, rx_valid = 0, rx_ready;
  int n_cmp = 0, n_err = 0;
  h2f_mailbox_slave dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_write(logic [2:0] a, logic [31:0] d, logic [3:0] be);
    avs_write = 1; avs_address = a; avs_writedata = d; avs_byteenable = be;
    @(posedge clk); #1;
    avs_write = 0;
  endtask
  task automatic do_read(logic [2:0] a, logic [31:0] exp, string name);
    avs_read = 1; avs_address = a;
    @(posedge clk); #1;
    avs_read = 0;
    check({name, " valid"}, 32'(avs_readdatavalid), 32'd1);
    check(name, avs_readdata, exp);
  endtask
  initial begin
    int word, acc;
    logic r;
    repeat (3) @(posedge clk);
    #1;
    check("rst readdata", avs_readdata, 0);
    check("rst rdvalid", 32'(avs_readdatavalid), 0);
    check("rst tx_valid", 32'(tx_valid), 0);
    check("rst tx_data", tx_data, 0);
    check("rst rx_ready", 32'(rx_ready), 0);
    reset = 0;
    @(posedge clk); #1;
    check("rx_ready rise", 32'(rx_ready), 1);
    tbl.push_back('{0, 3'd0, 0, 4'h0, 32'hC5B0_0001, "id"});
    tbl.push_back('{0, 3'd4, 0, 4'h0, 32'h000A_0000, "status empty"});
    tbl.push_back('{1, 3'd1, 32'hDEADBEEF, 4'b0101, 0, ""});
    tbl.push_back('{0, 3'd1, 0, 4'h0, 32'h00AD_00EF, "scratch be0101"});
    tbl.push_back('{1, 3'd1, 32'h12345678, 4'b1010, 0, ""});
    tbl.push_back('{0, 3'd1, 0, 4'h0, 32'h12AD_56EF, "scratch be1010"});
    tbl.push_back('{0, 3'd2, 0, 4'h0, 0, "txdata rd"});
    tbl.push_back('{0, 3'd5, 0, 4'h0, 0, "ctrl rd"});
    tbl.push_back('{0, 3'd6, 0, 4'h0, 0, "addr6 rd"});
    tbl.push_back('{0, 3'd7, 0, 4'h0, 0, "addr7 rd"});
    tbl.push_back('{1, 3'd6, 32'hFFFFFFFF, 4'hF, 0, ""});
    tbl.push_back('{0, 3'd1, 0, 4'h0, 32'h12AD_56EF, "addr6 wr ignored"});
    tbl.push_back('{1, 3'd2, 32'hAAAA0001, 4'hF, 0, ""});
    tbl.push_back('{0, 3'd4, 0, 4'h0, 32'h0008_0001, "status tx1"});
    tbl.push_back('{0, 3'd3, 0, 4'h0, 0, "rx underflow rd"});
    tbl.push_back('{0, 3'd4, 0, 4'h0, 32'h0028_0001, "status unf"});
    tbl.push_back('{1, 3'd5, 32'h4, 4'hF, 0, ""});
    tbl.push_back('{0, 3'd4, 0, 4'h0, 32'h0008_0001, "status clr"});
    tbl.push_back('{1, 3'd5, 32'h1, 4'hF, 0, ""});
    tbl.push_back('{0, 3'd4, 0, 4'h0, 32'h000A_0000, "status txflush"});
    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].be);
      else do_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    // read and write together: write wins, no response
    avs_read = 1; avs_write = 1; avs_address = 3'd1; avs_writedata = 0; avs_byteenable = 4'hF;
    @(posedge clk); #1;
    avs_read = 0; avs_write = 0;
    check("rw conflict no valid", 32'(avs_readdatavalid), 0);
    do_read(3'd1, 0, "rw conflict write done");
    @(posedge clk); #1;
    check("rdvalid one pulse", 32'(avs_readdatavalid), 0);
    do_write(3'd2, 32'd1, 4'hF);
    check("tx_valid after push", 32'(tx_valid), 1);
    check("tx_data after push", tx_data, 1);
    for (int i = 2; i <= 17; i++) do_write(3'd2, 32'(i), 4'hF);
    do_read(3'd4, 32'h0019_0010, "status tx overflow");
    tx_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      check("tx drain valid", 32'(tx_valid), 1);
      check("tx drain data", tx_data, 32'(i));
      @(posedge clk); #1;
    end
    tx_ready = 0;
    check("tx drained valid", 32'(tx_valid), 0);
    check("tx drained data", tx_data, 0);
    for (int i = 1; i <= 16; i++) do_write(3'd2, 32'(i), 4'hF);
    do_write(3'd5, 32'h4, 4'hF);
    tx_ready = 1;
    do_write(3'd2, 32'd99, 4'hF);
    tx_ready = 0;
    do_read(3'd4, 32'h0018_000F, "status full push+pop");
    do_write(3'd5, 32'h1, 4'hF);
    do_read(3'd4, 32'h001A_0000, "flush keeps sticky");
    do_write(3'd5, 32'h4, 4'hF);
    do_read(3'd4, 32'h000A_0000, "ctrl4 clears");
    for (int i = 1; i <= 4; i++) do_write(3'd2, 32'(i), 4'hF);
    tx_ready = 1;
    do_write(3'd5, 32'h1, 4'hF);
    tx_ready = 0;
    check("flush over pop valid", 32'(tx_valid), 0);
    do_read(3'd4, 32'h000A_0000, "status flush over pop");
    rx_valid = 1; word = 1; acc = 0;
    for (int c = 0; c < 30; c++) begin
      rx_data = 32'(word);
      r = rx_ready;
      @(posedge clk); #1;
      if (r) begin acc++; word++; end
    end
    rx_valid = 0;
    check("rx accepted", 32'(acc), 16);
    check("rx_ready full", 32'(rx_ready), 0);
    do_read(3'd4, 32'h0006_1000, "status rx full");
    rx_valid = 1; rx_data = 32'd100;
    do_read(3'd3, 32'd1, "rx pop when full");
    check("rx_ready reassert", 32'(rx_ready), 1);
    do_read(3'd4, 32'h0002_0F00, "status rx 15");
    check("rx_ready refill drop", 32'(rx_ready), 0);
    rx_valid = 0;
    do_read(3'd4, 32'h0006_1000, "status rx refilled");
    for (int i = 2; i <= 16; i++) do_read(3'd3, 32'(i), "rx drain");
    do_read(3'd3, 32'd100, "rx drain last");
    do_read(3'd3, 0, "rx empty rd");
    do_read(3'd4, 32'h002A_0000, "status rx unf");
    do_write(3'd5, 32'h4, 4'hF);
    rx_valid = 1; rx_data = 32'd55;
    do_read(3'd3, 0, "rx push+pop empty");
    rx_valid = 0;
    do_read(3'd4, 32'h0022_0100, "status push+pop empty");
    do_read(3'd3, 32'd55, "rx retained word");
    do_write(3'd5, 32'h4, 4'hF);
    rx_valid = 1; rx_data = 32'd7;
    @(posedge clk); #1;
    do_write(3'd5, 32'h2, 4'hF);
    rx_valid = 0;
    do_read(3'd4, 32'h000A_0000, "status rx flush over push");
    check("rx_ready after flush", 32'(rx_ready), 1);
    do_write(3'd2, 32'h11, 4'hF);
    avs_read = 1; avs_address = 3'd0;
    @(posedge clk); #1;
    avs_read = 0;
    #2 reset = 1;
    #1;
    check("async rst rdvalid", 32'(avs_readdatavalid), 0);
    check("async rst readdata", avs_readdata, 0);
    check("async rst tx_valid", 32'(tx_valid), 0);
    check("async rst rx_ready", 32'(rx_ready), 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    check("rx_ready after rst", 32'(rx_ready), 1);
    do_read(3'd0, 32'hC5B0_0001, "id after rst");
    do_read(3'd4, 32'h000A_0000, "status after rst");
    do_read(3'd1, 0, "scratch after rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
